// File: rtl/clk_gate_ctrl_pkg.sv
// Shared low-power definitions: gate FSM encoding and the settle/idle counter width.
// Imported by the clock-gate controller and its helpers.
package clk_gate_ctrl_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        OFF       = 2'b00,
        WAKE      = 2'b01,
        ON        = 2'b10,
        IDLE_WAIT = 2'b11
    } gate_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: +1 per inc pulse, holds at all-ones; synchronous clear.
// Single-cycle update, no backpressure (every inc is absorbed or saturated away).
module sat_counter #(
    parameter int STAT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              clear,
    output logic [STAT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && (cnt != {STAT_W{1'b1}})) begin
            cnt <= cnt + STAT_W'(1);
        end
    end

endmodule

// File: rtl/clk_gate_ctrl.sv
// Enable controller for one clock-gating cell: wake settle before gated_ready, idle hysteresis before gating off.
// CLK_EN rises one edge after req, gated_ready WAKE_CYCLES edges after req; no backpressure, req/busy are levels.
module clk_gate_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 4,
    parameter int STAT_W      = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req,
    input  logic              busy,
    output logic              CLK_EN,
    output logic              gated_ready,
    output logic [1:0]        gate_state,
    output logic [STAT_W-1:0] gate_off_cnt
);

    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);

    gate_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             idle_now;
    logic             gate_off_inc;

    assign idle_now = !req && !busy;

    // Same condition that takes IDLE_WAIT to OFF, so the statistic moves on that edge.
    assign gate_off_inc = (state_q == IDLE_WAIT) && idle_now && (cnt_q == '0);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= OFF;
            cnt_q       <= '0;
            CLK_EN      <= 1'b0;
            gated_ready <= 1'b0;
        end else begin
            case (state_q)
                OFF: begin
                    if (req) begin
                        state_q <= WAKE;
                        cnt_q   <= WAKE_LOAD;
                        CLK_EN  <= 1'b1;
                    end
                end
                // Wake always runs to completion so the domain never sees a runt clock burst.
                WAKE: begin
                    if (cnt_q == '0) begin
                        state_q     <= ON;
                        gated_ready <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ON: begin
                    if (idle_now) begin
                        state_q <= IDLE_WAIT;
                        cnt_q   <= IDLE_LOAD;
                    end
                end
                IDLE_WAIT: begin
                    if (!idle_now) begin
                        state_q <= ON;
                    end else if (cnt_q == '0) begin
                        state_q     <= OFF;
                        CLK_EN      <= 1'b0;
                        gated_ready <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q     <= OFF;
                    cnt_q       <= '0;
                    CLK_EN      <= 1'b0;
                    gated_ready <= 1'b0;
                end
            endcase
        end
    end

    assign gate_state = state_q;

    sat_counter #(
        .STAT_W (STAT_W)
    ) u_off_cnt (
        .clk   (CLK),
        .rst_n (RST),
        .inc   (gate_off_inc),
        .clear (1'b0),
        .cnt   (gate_off_cnt)
    );

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: per-cycle scoreboard of expected outputs plus directed latency/boundary checks.
module tb_clk_gate_ctrl;

    localparam int WAKE = 2;
    localparam int IDLE = 4;
    localparam int SW   = 2;
    localparam int SAT  = (1 << SW) - 1;

    typedef struct packed {
        logic          en;
        logic          rdy;
        logic [1:0]    st;
        logic [SW-1:0] off;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          req;
    logic          busy;
    logic          clk_en;
    logic          gated_ready;
    logic [1:0]    gate_state;
    logic [SW-1:0] gate_off_cnt;

    int   n_cmp;
    int   n_bad;
    exp_t sb_q[$];

    int m_st;
    int m_seen;
    int m_off;

    clk_gate_ctrl #(
        .WAKE_CYCLES (WAKE),
        .IDLE_CYCLES (IDLE),
        .STAT_W      (SW)
    ) dut (
        .CLK          (clk),
        .RST          (rst_n),
        .req          (req),
        .busy         (busy),
        .CLK_EN       (clk_en),
        .gated_ready  (gated_ready),
        .gate_state   (gate_state),
        .gate_off_cnt (gate_off_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st   = 0;
        m_seen = 0;
        m_off  = 0;
        sb_q.delete();
    endtask

    // Reference model counts elapsed edges in each phase; pushes the post-edge outputs.
    task automatic model_push(input logic r, input logic b);
        exp_t e;
        case (m_st)
            0: if (r) begin m_st = 1; m_seen = 0; end
            1: if (m_seen == WAKE - 1) m_st = 2; else m_seen++;
            2: if (!r && !b) begin m_st = 3; m_seen = 1; end
            default: begin
                if (r || b) m_st = 2;
                else if (m_seen == IDLE) begin
                    m_st  = 0;
                    m_off = (m_off < SAT) ? m_off + 1 : SAT;
                end else m_seen++;
            end
        endcase
        e.en  = (m_st != 0);
        e.rdy = (m_st >= 2);
        e.st  = 2'(m_st);
        e.off = SW'(m_off);
        sb_q.push_back(e);
    endtask

    // Drive one cycle of inputs, let the edge happen, then retire the oldest expectation.
    task automatic step(input logic r, input logic b);
        exp_t e;
        req  = r;
        busy = b;
        model_push(r, b);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk_eq("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk_eq("sb_clk_en", 32'(clk_en), 32'(e.en));
            chk_eq("sb_ready", 32'(gated_ready), 32'(e.rdy));
            chk_eq("sb_state", 32'(gate_state), 32'(e.st));
            chk_eq("sb_off_cnt", 32'(gate_off_cnt), 32'(e.off));
        end
    endtask

    task automatic wake_up();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        model_reset();
        rst_n = 1'b0;
        req   = 1'b0;
        busy  = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_eq("rst_clk_en", 32'(clk_en), 32'd0);
            chk_eq("rst_ready", 32'(gated_ready), 32'd0);
            chk_eq("rst_state", 32'(gate_state), 32'd0);
            chk_eq("rst_off_cnt", 32'(gate_off_cnt), 32'd0);
        end
        rst_n = 1'b1;

        // busy alone must not wake the domain
        for (int i = 0; i < 20; i++) step(1'b0, (i % 5) == 2);
        chk_eq("idle_stays_off", 32'(gate_state), 32'd0);

        step(1'b1, 1'b0);
        chk_eq("wake_en_1edge", 32'(clk_en), 32'd1);
        chk_eq("wake_state", 32'(gate_state), 32'd1);
        step(1'b1, 1'b0);
        chk_eq("wake_not_ready", 32'(gated_ready), 32'd0);
        step(1'b1, 1'b0);
        chk_eq("wake_ready_2edge", 32'(gated_ready), 32'd1);
        chk_eq("wake_on_state", 32'(gate_state), 32'd2);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);

        step(1'b0, 1'b0);
        chk_eq("idle_enter", 32'(gate_state), 32'd3);
        for (int i = 0; i < IDLE - 1; i++) step(1'b0, 1'b0);
        chk_eq("idle_still_en", 32'(clk_en), 32'd1);
        step(1'b0, 1'b0);
        chk_eq("idle_off_en", 32'(clk_en), 32'd0);
        chk_eq("idle_off_ready", 32'(gated_ready), 32'd0);
        chk_eq("idle_off_cnt1", 32'(gate_off_cnt), 32'd1);

        // abort at cnt==1, then a full fresh window is required
        wake_up();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk_eq("abort_on", 32'(gate_state), 32'd2);
        chk_eq("abort_en", 32'(clk_en), 32'd1);
        step(1'b0, 1'b0);
        for (int i = 0; i < IDLE - 1; i++) step(1'b0, 1'b0);
        chk_eq("abort_fresh_window", 32'(gate_state), 32'd3);
        chk_eq("abort_cnt_same", 32'(gate_off_cnt), 32'd1);
        step(1'b0, 1'b0);
        chk_eq("abort_then_off", 32'(gate_state), 32'd0);
        chk_eq("abort_off_cnt2", 32'(gate_off_cnt), 32'd2);

        // single-cycle req pulse still completes the wake
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk_eq("pulse_in_wake", 32'(gate_state), 32'd1);
        step(1'b0, 1'b0);
        chk_eq("pulse_on", 32'(gate_state), 32'd2);
        step(1'b0, 1'b0);
        chk_eq("pulse_idle", 32'(gate_state), 32'd3);
        for (int i = 0; i < IDLE; i++) step(1'b0, 1'b0);
        chk_eq("pulse_off", 32'(gate_state), 32'd0);
        chk_eq("pulse_off_cnt3", 32'(gate_off_cnt), 32'd3);

        for (int k = 0; k < 3; k++) begin
            wake_up();
            for (int i = 0; i < IDLE + 1; i++) step(1'b0, 1'b0);
        end
        chk_eq("sat_hold", 32'(gate_off_cnt), 32'(SAT));

        // asynchronous reset in the middle of WAKE, between clock edges
        step(1'b1, 1'b0);
        chk_eq("pre_rst_wake", 32'(gate_state), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("arst_clk_en", 32'(clk_en), 32'd0);
        chk_eq("arst_off_cnt", 32'(gate_off_cnt), 32'd0);
        chk_eq("arst_state", 32'(gate_state), 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 3) != 0) ? (i % 40 < 20) : ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clk_gate_ctrl.md
Name: clk_gate_ctrl

Overview:
- Enable-side controller that drives the CLK_EN input of the clock-gating cell for one gated domain, such as the ALU clock.
- Turns a level request plus a domain-busy indication into a glitch-free, registered CLK_EN.
- Provides a programmable wake-up settle time before reporting the clock ready, and an idle hysteresis before gating the clock off.
- Counts gate-off events for low-power statistics. It sits in the system-controller clock domain, next to the gating cell it drives.

Parameters:
- WAKE_CYCLES, 2, cycles from accepted request until gated_ready asserts (legal range 1..255).
- IDLE_CYCLES, 4, consecutive idle cycles in ON before CLK_EN drops (legal range 1..255).
- STAT_W, 8, width of the saturating gate-off event counter.

Ports:
- CLK  input  1  reference clock; the same clock feeds the gating cell.
- RST  input  1  asynchronous, active-low reset.
- req  input  1  level; the requester needs the gated clock running.
- busy  input  1  the gated domain still has work in flight (CLK-synchronous).
- CLK_EN  output  1  registered enable to the clock-gating cell.
- gated_ready  output  1  registered; the gated clock is stable and usable.
- gate_state  output  2  registered FSM state: 00 OFF, 01 WAKE, 10 ON, 11 IDLE_WAIT.
- gate_off_cnt  output  STAT_W  number of ON-to-OFF transitions, saturating.

Behaviour:
- One clock, CLK. Reset RST is asynchronous and active-low. All outputs are registered; there is no combinational path from any input to any output.
- Reset values:
  - state is OFF
  - CLK_EN=0, gated_ready=0, gate_state=00
  - gate_off_cnt=0
  - internal down-counter cnt=0; cnt is 8 bits.
- OFF: CLK_EN=0, gated_ready=0.
  - Edge with req=1: go to WAKE, cnt<=WAKE_CYCLES-1, CLK_EN<=1.
  - busy alone does not wake the domain.
- WAKE: CLK_EN=1, gated_ready=0.
  - Edge with cnt==0: go to ON, gated_ready<=1.
  - Otherwise cnt<=cnt-1.
  - req and busy are ignored; wake always completes, even if req drops.
- ON: CLK_EN=1, gated_ready=1.
  - Edge with req=0 and busy=0: go to IDLE_WAIT, cnt<=IDLE_CYCLES-1.
- IDLE_WAIT: CLK_EN=1, gated_ready=1.
  - Edge with req=1 or busy=1: return to ON. This abort has priority over expiry.
  - Else, edge with cnt==0: go to OFF, CLK_EN<=0, gated_ready<=0, and gate_off_cnt<=gate_off_cnt+1, holding at all-ones.
  - Else cnt<=cnt-1.
- Latency:
  - req sampled at edge n in OFF gives CLK_EN high after edge n and gated_ready high after edge n+WAKE_CYCLES.
  - The first idle-sampled edge m in ON gives CLK_EN low after edge m+IDLE_CYCLES, if idle persists.
- CLK_EN and gated_ready fall on the same edge.
- CLK_EN changes only on the rising edge of CLK. This is safe because the gating cell latches its enable while CLK is low.
- Requester contract: hold req high for as long as the clock is used; act only while gated_ready=1.
- Reset mid-operation (any state): immediate return to OFF with CLK_EN=0. gate_off_cnt is cleared and not incremented.
- Illegal state encoding cannot occur (2-bit, all 4 states used). The default branch goes to OFF.

Decomposition:
- Shared low-power package holds:
  - the state encoding constants OFF/WAKE/ON/IDLE_WAIT (2-bit)
  - the 8-bit width of the settle/idle counter.
- No sub-module is required. Optionally, the saturating counter may be factored into sat_counter (parameter STAT_W; inputs inc and clear).

Test Plan:
- Reset then idle inputs: RST low for 3 cycles, req=0, busy=0 for 20 cycles -> CLK_EN=0, gated_ready=0, gate_state=00, gate_off_cnt=0 throughout.
- Wake latency, defaults: req rises before edge 10 -> CLK_EN=1 after edge 10, gate_state=01, gated_ready=1 and gate_state=10 after edge 12.
- Idle gating: in ON, drop req and busy before edge 20 -> gate_state=11 after edge 20, CLK_EN=0 and gated_ready=0 after edge 24, gate_off_cnt=1.
- Idle abort: in IDLE_WAIT, busy=1 for 1 cycle at cnt=1 -> return to ON, CLK_EN stays 1; a fresh full 4-cycle idle window is needed before gating off; gate_off_cnt unchanged.
- Wake not abortable: req pulses 1 cycle in OFF -> WAKE completes, ON for 1 edge, then IDLE_WAIT, then OFF 4 edges later; gate_off_cnt +1.
- Saturation and async reset: STAT_W=2, 5 wake/idle cycles -> gate_off_cnt stays 3. Assert RST mid-WAKE -> CLK_EN=0 and gate_off_cnt=0 immediately, without waiting for a CLK edge.
